// File: rtl/retire_trace_pkg.sv
// Shared state encoding and entry widths for the retirement trace buffer.
// Defining RETIRE_TRACE_TIMESTAMP_EN widens each entry by a 32-bit capture timestamp.
package retire_trace_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } state_e;

    localparam int unsigned PcW        = 32;
    localparam int unsigned WbAddrW    = 5;
    localparam int unsigned WbDataW    = 32;
    localparam int unsigned MemAddrW   = 32;
    localparam int unsigned TsW        = 32;
    localparam int unsigned BaseEntryW = PcW + 1 + WbAddrW + WbDataW + 1 + MemAddrW;

`ifdef RETIRE_TRACE_TIMESTAMP_EN
    localparam int unsigned EntryW = BaseEntryW + TsW;
`else
    localparam int unsigned EntryW = BaseEntryW;
`endif

endpackage

// File: rtl/trace_fifo.sv
// Generic first-word-fall-through synchronous FIFO with occupancy output.
// A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   fill_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      fill_q;
    logic             do_push, do_pop;

    assign full_o  = (fill_q == FullCnt);
    assign empty_o = (fill_q == '0);
    assign fill_o  = fill_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

endmodule

// File: rtl/retire_trace_buffer.sv
// Triggered capture of CPU retirements into a FWFT FIFO drained over valid/ready.
// Optional RETIRE_TRACE_TIMESTAMP_EN adds a free-running cycle stamp and the trace_ts port.
module retire_trace_buffer
    import retire_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     trig_any,
    input  logic [31:0]              trig_pc,
    input  logic [CNT_W-1:0]         cap_len,
    input  logic                     retire_valid,
    input  logic [31:0]              retire_pc,
    input  logic                     wb_en,
    input  logic [4:0]               wb_addr,
    input  logic [31:0]              wb_data,
    input  logic                     mem_we,
    input  logic [31:0]              mem_addr,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [31:0]              trace_pc,
    output logic                     trace_wb_en,
    output logic [4:0]               trace_wb_addr,
    output logic [31:0]              trace_wb_data,
    output logic                     trace_mem_we,
    output logic [31:0]              trace_mem_addr,
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    output logic [31:0]              trace_ts,
`endif
    output logic [$clog2(DEPTH):0]   fill,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [1:0]               state_o
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  obs_q, obs_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic              capture;
    logic              pop;
    logic              full;
    logic              empty;
    logic [EntryW-1:0] wdata;
    logic [EntryW-1:0] rdata;

    assign pop         = trace_valid && trace_ready;
    assign trace_valid = !empty;
    assign state_o     = state_q;
    assign drop_cnt    = drop_q;

    always_comb begin
        state_d = state_q;
        obs_d   = obs_q;
        len_d   = len_q;
        drop_d  = drop_q;
        capture = 1'b0;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (arm) begin
                        state_d = StArmed;
                        obs_d   = '0;
                        drop_d  = '0;
                    end
                end
                StArmed: begin
                    if (retire_valid && (trig_any || retire_pc == trig_pc)) begin
                        capture = 1'b1;
                        obs_d   = CNT_W'(1);
                        len_d   = cap_len;
                        state_d = (cap_len == CNT_W'(1)) ? StDone : StCapture;
                    end
                end
                StCapture: begin
                    if (retire_valid) begin
                        capture = 1'b1;
                        obs_d   = obs_q + 1'b1;
                        if (len_q != '0 && obs_d == len_q) begin
                            state_d = StDone;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        // A dropped capture still advances the observed count above.
        if (capture && full && !pop && drop_q != '1) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            obs_q   <= '0;
            len_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            obs_q   <= obs_d;
            len_q   <= len_d;
            drop_q  <= drop_d;
        end
    end

`ifdef RETIRE_TRACE_TIMESTAMP_EN
    logic [TsW-1:0] ts_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign wdata = {retire_pc, wb_en, wb_addr, wb_data, mem_we, mem_addr, ts_q};
    assign {trace_pc, trace_wb_en, trace_wb_addr, trace_wb_data, trace_mem_we, trace_mem_addr,
            trace_ts} = rdata;
`else
    assign wdata = {retire_pc, wb_en, wb_addr, wb_data, mem_we, mem_addr};
    assign {trace_pc, trace_wb_en, trace_wb_addr, trace_wb_data, trace_mem_we,
            trace_mem_addr} = rdata;
`endif

    trace_fifo #(
        .WIDTH (EntryW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (capture),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .fill_o  (fill)
    );

endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
- Synthesizable retirement monitor downstream of the single-cycle cpu. Consumes per-instruction commit information: PC, register write-back and data-memory store.
- Captures a triggered window of retirements into an on-chip FIFO.
- A host or debug port drains the FIFO through a valid/ready interface.
- Replaces per-cycle console dumps for on-board debug.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the capture-length input and of the drop counter.

Ports:
- clk  input  1  rising-edge clock shared with cpu
- rst_n  input  1  synchronous active-low reset
- arm  input  1  one-cycle pulse; start waiting for trigger
- abort  input  1  one-cycle pulse; stop capture immediately
- trig_any  input  1  1 = trigger on the first retirement after arm; 0 = trigger on PC match
- trig_pc  input  32  trigger PC
- cap_len  input  CNT_W  retirements to observe per window; 0 = unlimited
- retire_valid  input  1  one instruction retires this cycle
- retire_pc  input  32  PC of the retiring instruction
- wb_en  input  1  register write-back occurs
- wb_addr  input  5  write-back register number
- wb_data  input  32  write-back data
- mem_we  input  1  data-memory store occurs
- mem_addr  input  32  store address
- trace_valid  output  1  FIFO head entry present
- trace_ready  input  1  consumer accepts the head entry
- trace_pc  output  32  head entry PC
- trace_wb_en  output  1  head entry write-back flag
- trace_wb_addr  output  5  head entry write-back register
- trace_wb_data  output  32  head entry write-back data
- trace_mem_we  output  1  head entry store flag
- trace_mem_addr  output  32  head entry store address
- fill  output  log2(DEPTH)+1  current occupancy
- drop_cnt  output  CNT_W  entries lost to a full FIFO; saturating
- state_o  output  2  current FSM state

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state = IDLE; FIFO empty; fill = 0; drop_cnt = 0; observed counter = 0.
  - trace_valid = 0; all trace_* data outputs = 0.
- FSM states: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- Transitions:
  - abort: any state -> IDLE. abort has priority over arm and over a trigger in the same cycle.
  - arm in IDLE or DONE -> ARMED. Clears the observed counter and drop_cnt. Does not clear FIFO contents.
  - arm in ARMED or CAPTURE is ignored.
  - ARMED + retire_valid + (trig_any or retire_pc == trig_pc):
    - The triggering retirement is captured.
    - Observed counter = 1.
    - Next state = CAPTURE, or DONE if cap_len == 1.
  - CAPTURE + retire_valid: capture and increment the observed counter. When the counter reaches cap_len (cap_len != 0), next state = DONE; that last retirement is still captured.
  - cap_len is sampled when the trigger fires. Later changes are ignored until the next arm.
- Capture write:
  - Pushes {retire_pc, wb_en, wb_addr, wb_data, mem_we, mem_addr} into the FIFO at the clk edge.
  - Retirements in IDLE, DONE or ARMED (without a trigger match) are not recorded.
- Full FIFO:
  - A capture that arrives when the FIFO is full and no pop happens that cycle is dropped.
  - drop_cnt increments and saturates at all-ones.
  - A dropped capture still counts toward cap_len.
- Simultaneous push and pop:
  - Full: both accepted; fill unchanged.
  - Empty: no pop possible; push accepted.
- Drain interface:
  - First-word-fall-through. trace_valid = (fill != 0).
  - trace_* data outputs present the head entry combinationally from storage.
  - Pop occurs when trace_valid && trace_ready at the clk edge.
  - Head data are held stable while trace_valid=1 and trace_ready=0.
  - trace_ready while empty has no effect.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. fill is tracked separately with range 0..DEPTH.
- Latency: a captured retirement appears on trace_* one cycle after its clk edge when the FIFO was empty.
- Reset in mid-capture: all state, FIFO contents and counters are cleared on the same edge.

Optional Feature:
- Macro: RETIRE_TRACE_TIMESTAMP_EN.
- Defined:
  - A free-running 32-bit cycle counter is added. It is reset to 0, increments every clk and wraps.
  - Each entry stores the counter value at its capture edge.
  - Extra output port trace_ts (32) presents the head entry timestamp.
- Undefined: no counter, no storage for it, and no trace_ts port.

Decomposition:
- Package retire_trace_pkg:
  - FSM state encoding constants (IDLE, ARMED, CAPTURE, DONE).
  - Entry field widths and the packed entry width (103 bits, or 135 with the timestamp).
- Sub-module trace_fifo: a generic FWFT synchronous FIFO with parameters WIDTH and DEPTH. Outputs full, empty and fill. Implements the simultaneous push/pop rules above.
- Top-level logic contains the FSM, trigger compare, observed counter and drop counter.

Test Plan:
1. Reset, then arm with trig_any=1, cap_len=3, five back-to-back retirements at PCs 0x00..0x10, trace_ready=0 -> state ARMED->CAPTURE->DONE; fill=3; head PC=0x00; drop_cnt=0.
2. trig_any=0, trig_pc=0x0C, retirements at PC 0x00,0x04,0x08,0x0C,0x10 with cap_len=2 -> exactly PCs 0x0C and 0x10 captured; state DONE.
3. DEPTH=16, cap_len=0, 20 retirements with trace_ready=0 -> fill=16; drop_cnt=4; state stays CAPTURE. Then drain with trace_ready=1 -> 16 entries popped in order; trace_valid=0 afterwards.
4. FIFO full with trace_ready=1 and retire_valid=1 in the same cycle -> fill stays 16; no drop; the oldest entry is popped and the new entry is appended.
5. abort and arm in the same cycle during CAPTURE -> state IDLE; further retirements not recorded. rst_n=0 for one edge in CAPTURE -> fill=0, drop_cnt=0, state IDLE.
6. With RETIRE_TRACE_TIMESTAMP_EN, capture 2 retirements 3 cycles apart -> trace_ts of the second entry minus the first = 3.
